// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - opcode encodings, FSM states, strobe constants and op decode helpers
package mem_access_ctrl_pkg;

  localparam logic [5:0] EXE_LB  = 6'b100000;
  localparam logic [5:0] EXE_LH  = 6'b100001;
  localparam logic [5:0] EXE_LW  = 6'b100011;
  localparam logic [5:0] EXE_LBU = 6'b100100;
  localparam logic [5:0] EXE_LHU = 6'b100101;
  localparam logic [5:0] EXE_SB  = 6'b101000;
  localparam logic [5:0] EXE_SH  = 6'b101001;
  localparam logic [5:0] EXE_SW  = 6'b101011;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [3:0] STRB_NONE    = 4'b0000;
  localparam logic [3:0] STRB_BYTE    = 4'b0001;
  localparam logic [3:0] STRB_HALF_LO = 4'b0011;
  localparam logic [3:0] STRB_HALF_HI = 4'b1100;
  localparam logic [3:0] STRB_WORD    = 4'b1111;

  function automatic logic is_mem_op(input logic [5:0] op);
    case (op)
      EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU, EXE_SB, EXE_SH, EXE_SW: is_mem_op = 1'b1;
      default: is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
    case (op)
      EXE_LH, EXE_LHU, EXE_SH: is_misaligned = lo[0];
      EXE_LW, EXE_SW:          is_misaligned = |lo;
      default:                 is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_fmt.sv
// rtl/mem_access_ctrl_lane_fmt.sv - combinational byte-lane formatter (mem_lane_fmt)
// Produces store strobes, lane-replicated store data and extended load data.
module mem_lane_fmt
  import mem_access_ctrl_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_ld_word,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata_rep,
  output logic [31:0] o_rdata_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_ld_word[7:0];
      2'd1:    w_byte = i_ld_word[15:8];
      2'd2:    w_byte = i_ld_word[23:16];
      default: w_byte = i_ld_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];
  end

  always_comb begin
    o_wstrb     = STRB_NONE;
    o_wdata_rep = i_st_data;
    o_rdata_ext = i_ld_word;
    case (i_op)
      EXE_SB: begin
        o_wstrb     = STRB_BYTE << i_addr_lo;
        o_wdata_rep = {4{i_st_data[7:0]}};
      end
      EXE_SH: begin
        o_wstrb     = i_addr_lo[1] ? STRB_HALF_HI : STRB_HALF_LO;
        o_wdata_rep = {2{i_st_data[15:0]}};
      end
      EXE_SW:  o_wstrb = STRB_WORD;
      EXE_LB:  o_rdata_ext = {{24{w_byte[7]}}, w_byte};
      EXE_LBU: o_rdata_ext = {24'd0, w_byte};
      EXE_LH:  o_rdata_ext = {{16{w_half[15]}}, w_half};
      EXE_LHU: o_rdata_ext = {16'd0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer on a req/addr_ok/data_ok SRAM bus
// Optional MEM_ADDR_EXC_EN: misaligned half/word accesses raise adel_o/ades_o instead of a request.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OPC_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [OPC_W-1:0]  op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              flush,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic              data_req,
  output logic              data_wr,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic [31:0]       data_rdata,
  input  logic              data_data_ok
);

  logic [2:0]        r_state;
  logic [OPC_W-1:0]  r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;
  logic              r_wr;
  logic              w_go;
  logic              w_mis;
  logic [3:0]        w_wstrb;

  assign w_go = mem_en & !flush;

`ifdef MEM_ADDR_EXC_EN
  logic r_adel;
  logic r_ades;

  assign w_mis = is_mem_op(op) & is_misaligned(op, addr[1:0]);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_adel <= 1'b0;
      r_ades <= 1'b0;
    end else begin
      r_adel <= (r_state == ST_IDLE) & w_go & w_mis & !mem_wr;
      r_ades <= (r_state == ST_IDLE) & w_go & w_mis & mem_wr;
    end
  end

  assign adel_o = r_adel;
  assign ades_o = r_ades;
`else
  assign w_mis  = 1'b0;
  assign adel_o = 1'b0;
  assign ades_o = 1'b0;
`endif

  always_comb begin
    case (r_state)
      ST_IDLE:          stall_o = w_go & !w_mis;
      ST_REQ, ST_WAIT:  stall_o = !flush;
      default:          stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
      r_wr    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_go && !w_mis) begin
          r_op    <= op;
          r_addr  <= addr;
          r_wdata <= wdata;
          r_wr    <= mem_wr;
          r_state <= is_mem_op(op) ? ST_REQ : ST_DONE;
        end
        // An accepted request with its response still outstanding must be drained.
        ST_REQ: if (flush) begin
          r_state <= (data_addr_ok && !data_data_ok) ? ST_DRAIN : ST_IDLE;
        end else if (data_addr_ok) begin
          if (data_data_ok) begin
            r_word  <= data_rdata;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: if (data_data_ok) begin
          if (!flush) r_word <= data_rdata;
          r_state <= flush ? ST_IDLE : ST_DONE;
        end else if (flush) begin
          r_state <= ST_DRAIN;
        end
        ST_DONE:  r_state <= ST_IDLE;
        ST_DRAIN: if (data_data_ok) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  mem_lane_fmt u_lane_fmt (
    .i_op        (r_op),
    .i_addr_lo   (r_addr[1:0]),
    .i_st_data   (r_wdata),
    .i_ld_word   (r_word),
    .o_wstrb     (w_wstrb),
    .o_wdata_rep (data_wdata),
    .o_rdata_ext (rdata_o)
  );

  assign data_req   = (r_state == ST_REQ);
  assign data_wr    = data_req & r_wr;
  assign data_wstrb = data_req ? w_wstrb : STRB_NONE;
  assign data_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign done_o     = (r_state == ST_DONE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, mem_en, mem_wr, flush;
  logic [5:0]  op;
  logic [31:0] addr, wdata;
  logic        stall_o, done_o, adel_o, ades_o;
  logic [31:0] rdata_o;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  int          n_stall, req_cycles;
  logic        saw_done, unstable, idle_stall;
  logic [31:0] got_rdata, c_addr, c_wdata;
  logic [3:0]  c_wstrb;
  logic        c_wr;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .OPC_W(6)) dut (
    .clk(clk), .resetn(resetn), .mem_en(mem_en), .mem_wr(mem_wr), .op(op),
    .addr(addr), .wdata(wdata), .flush(flush), .stall_o(stall_o),
    .rdata_o(rdata_o), .done_o(done_o), .adel_o(adel_o), .ades_o(ades_o),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; addr_ok arrives n_a cycles into the access, data_ok n_d after that.
  task automatic run_access(input logic [5:0] t_op, input logic [31:0] t_addr, input logic t_wr,
                            input logic [31:0] t_wd, input logic [31:0] t_word,
                            input int n_a, input int n_d);
    mem_en = 1'b1; mem_wr = t_wr; op = t_op; addr = t_addr; wdata = t_wd; data_rdata = t_word;
    n_stall = 0; req_cycles = 0; saw_done = 1'b0; unstable = 1'b0; got_rdata = 'x;
    #1 idle_stall = stall_o;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      data_addr_ok = (cyc == n_a);
      data_data_ok = (cyc == n_a + n_d);
      @(negedge clk);
      if (stall_o) n_stall++;
      if (data_req) begin
        if (req_cycles == 0) begin
          c_addr = data_addr; c_wdata = data_wdata; c_wstrb = data_wstrb; c_wr = data_wr;
        end else if (c_addr !== data_addr || c_wdata !== data_wdata ||
                     c_wstrb !== data_wstrb || c_wr !== data_wr) begin
          unstable = 1'b1;
        end
        req_cycles++;
      end
      if (done_o) begin
        saw_done = 1'b1;
        got_rdata = rdata_o;
      end
      @(posedge clk); #1;
      if (saw_done) break;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0; mem_en = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; mem_en = 1'b0; mem_wr = 1'b0; flush = 1'b0; op = '0;
    addr = '0; wdata = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_wstrb", {28'd0, data_wstrb}, 32'd0);
    chk("rst_exc", {30'd0, adel_o, ades_o}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_access(EXE_LB, 32'h0000_1003, 1'b0, 32'h0, 32'h80FF_1234, 0, 0);
    chk("lb_idle_stall", {31'd0, idle_stall}, 32'd1);
    chk("lb_wstrb", {28'd0, c_wstrb}, 32'h0);
    chk("lb_addr", c_addr, 32'h0000_1000);
    chk("lb_done", {31'd0, saw_done}, 32'd1);
    chk("lb_rdata", got_rdata, 32'hFFFF_FF80);
    chk("lb_stall_cycles", n_stall, 1);

    run_access(EXE_SH, 32'h0000_2002, 1'b1, 32'hAAAA_BEEF, 32'h0, 3, 2);
    chk("sh_wstrb", {28'd0, c_wstrb}, 32'hC);
    chk("sh_wdata", c_wdata, 32'hBEEF_BEEF);
    chk("sh_wr", {31'd0, c_wr}, 32'd1);
    chk("sh_stable", {31'd0, unstable}, 32'd0);
    chk("sh_req_cycles", req_cycles, 4);
    chk("sh_stall_cycles", n_stall, 6);
    chk("sh_done", {31'd0, saw_done}, 32'd1);

    run_access(EXE_LHU, 32'h0000_3000, 1'b0, 32'h0, 32'h8001_8765, 1, 1);
    chk("lhu_rdata", got_rdata, 32'h0000_8765);
    run_access(EXE_LW, 32'h0000_3000, 1'b0, 32'h0, 32'h8001_8765, 0, 1);
    chk("lw_rdata", got_rdata, 32'h8001_8765);
    run_access(EXE_LH, 32'h0000_3002, 1'b0, 32'h0, 32'h8001_8765, 0, 0);
    chk("lh_rdata", got_rdata, 32'hFFFF_8001);
    run_access(EXE_LBU, 32'h0000_1003, 1'b0, 32'h0, 32'h80FF_1234, 0, 0);
    chk("lbu_rdata", got_rdata, 32'h0000_0080);
    run_access(EXE_SB, 32'h0000_1002, 1'b1, 32'h0000_00A5, 32'h0, 0, 0);
    chk("sb_wstrb", {28'd0, c_wstrb}, 32'h4);
    chk("sb_wdata", c_wdata, 32'hA5A5_A5A5);

    run_access(6'b000000, 32'h0000_0010, 1'b0, 32'h0, 32'h0, 0, 0);
    chk("nop_req", req_cycles, 0);
    chk("nop_done", {31'd0, saw_done}, 32'd1);
    chk("nop_stall", n_stall, 0);

    // Flush while the response is outstanding: drain it, never signal done.
    mem_en = 1'b1; mem_wr = 1'b0; op = EXE_LW; addr = 32'h0000_5000; data_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_wait_req", {31'd0, data_req}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; mem_en = 1'b0;
    @(negedge clk);
    chk("drain_done", {31'd0, done_o}, 32'd0);
    chk("drain_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b1;
    @(negedge clk);
    chk("drain_ok_done", {31'd0, done_o}, 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("drain_exit_done", {31'd0, done_o}, 32'd0);
    chk("drain_exit_req", {31'd0, data_req}, 32'd0);
    @(posedge clk); #1;
    run_access(EXE_SW, 32'h0000_6000, 1'b1, 32'h1122_3344, 32'h0, 1, 1);
    chk("sw_wstrb", {28'd0, c_wstrb}, 32'hF);
    chk("sw_wdata", c_wdata, 32'h1122_3344);
    chk("sw_done", {31'd0, saw_done}, 32'd1);

    // Reset mid-access; a late data_ok must be ignored.
    mem_en = 1'b1; mem_wr = 1'b0; op = EXE_LW; addr = 32'h0000_7000; data_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; resetn = 1'b0; mem_en = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1; data_data_ok = 1'b1;
    @(negedge clk);
    chk("rstw_req", {31'd0, data_req}, 32'd0);
    chk("rstw_stall", {31'd0, stall_o}, 32'd0);
    chk("rstw_done", {31'd0, done_o}, 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("rstw_stale_done", {31'd0, done_o}, 32'd0);
    chk("rstw_rdata", rdata_o, 32'd0);
    @(posedge clk); #1;

`ifdef MEM_ADDR_EXC_EN
    mem_en = 1'b1; mem_wr = 1'b0; op = EXE_LW; addr = 32'h0000_4001;
    @(negedge clk);
    chk("mis_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    mem_en = 1'b0;
    @(negedge clk);
    chk("mis_adel", {31'd0, adel_o}, 32'd1);
    chk("mis_ades", {31'd0, ades_o}, 32'd0);
    chk("mis_req", {31'd0, data_req}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis_adel_pulse", {31'd0, adel_o}, 32'd0);
    chk("mis_req2", {31'd0, data_req}, 32'd0);
    @(posedge clk); #1;
`else
    run_access(EXE_LW, 32'h0000_4001, 1'b0, 32'h0, 32'h1234_5678, 0, 1);
    chk("mis_addr", c_addr, 32'h0000_4000);
    chk("mis_rdata", got_rdata, 32'h1234_5678);
    chk("mis_adel", {31'd0, adel_o}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences one MEM-stage load/store (LW/LH/LHU/LB/LBU/SW/SH/SB, selected by the main decoder's memtoreg/memwrite) onto the data-SRAM bus using a req / addr_ok / data_ok handshake.
- Generates byte strobes and store-data lane replication, and sign- or zero-extends load data.
- Holds the pipeline stalled until the access completes.
- Sits between the MEM stage of the datapath and the data-memory bridge.

Parameters:
- ADDR_W, 32, width of the data address bus.
- OPC_W, 6, width of the opcode field; encodings come from the shared defines.

Ports:
- clk  in  1  clock; all logic rises on posedge.
- resetn  in  1  synchronous reset, active-low.
- mem_en  in  1  MEM stage holds a valid load/store (memtoreg|memwrite).
- mem_wr  in  1  1 = store, 0 = load (memwrite).
- op  in  OPC_W  instruction opcode.
- addr  in  ADDR_W  effective address.
- wdata  in  32  store data, rt value.
- flush  in  1  kill the current MEM instruction.
- stall_o  out  1  freeze the pipeline.
- rdata_o  out  32  extended load result.
- done_o  out  1  one-cycle pulse: access finished, pipeline advances.
- adel_o  out  1  load address-error pulse.
- ades_o  out  1  store address-error pulse.
- data_req  out  1  bus request.
- data_wr  out  1  bus write.
- data_wstrb  out  4  byte strobes.
- data_addr  out  ADDR_W  word-aligned bus address.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  request accepted.
- data_rdata  in  32  read data.
- data_data_ok  in  1  response valid.

Behaviour:
- States: IDLE, REQ, WAIT, DONE, DRAIN. Reset (resetn=0 at posedge, any state, including mid-access):
  - state=IDLE.
  - data_req, data_wr, data_wstrb, done_o, adel_o, ades_o = 0.
  - rdata_o = 0.
- IDLE:
  - mem_en & !flush & !misaligned: latch op, addr, wdata into registers, go to REQ.
  - stall_o = mem_en & !flush (combinational), so the instruction is frozen from its first cycle.
- REQ:
  - data_req=1; bus fields driven from the registers.
  - addr_ok & data_ok in the same cycle: capture data_rdata, go to DONE.
  - addr_ok only: go to WAIT.
  - Neither: stay in REQ; request fields must be held stable.
- WAIT:
  - data_req=0.
  - data_ok: capture data_rdata into the result register, go to DONE.
- DONE:
  - stall_o=0, done_o=1 for exactly one cycle; rdata_o valid.
  - Always returns to IDLE. No new access may launch in DONE; the next instruction is sampled in IDLE.
- Flush in REQ before addr_ok: go to IDLE; data_req drops the next cycle.
- Flush in REQ with addr_ok, or any flush in WAIT: go to DRAIN.
- DRAIN: stall_o=0; wait for data_ok, discard data, go to IDLE. done_o is never raised. A new mem_en is not accepted until IDLE.
- Bus addressing: data_addr = {addr[ADDR_W-1:2],2'b00}; data_wr = registered mem_wr.
- Strobes and store data (little-endian):
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'b1111.
  - Loads: wstrb = 4'b0000.
- Load extraction from the captured word:
  - LB/LBU: byte at addr[1:0], sign/zero extended.
  - LH/LHU: half at addr[1], sign/zero extended.
  - LW: whole word.
- A non-memory op with mem_en=1 is treated as a no-op: no request, done_o pulses next cycle.
- stall_o is combinational. All other outputs are registered or decoded from registered state.

Optional Feature:
- MEM_ADDR_EXC_EN defined:
  - Misaligned halfword (addr[0]=1) or word (addr[1:0]≠0) access in IDLE issues no bus request.
  - Pulses adel_o (load) or ades_o (store) for one cycle. stall_o=0 that cycle.
  - Flush suppresses the pulse.
- MEM_ADDR_EXC_EN undefined:
  - adel_o = ades_o = 0 constant.
  - Misaligned low bits are ignored: halfword uses addr[1], word uses 0.

Decomposition:
- Shared defines file: opcode macros, the state encoding localparams, and strobe constants. The opcode macros are the existing EXE_LW/LH/LHU/LB/LBU/SW/SH/SB encodings.
- One natural sub-module: mem_lane_fmt, purely combinational. Given op, addr[1:0], store data and raw read data, it produces wstrb, replicated wdata and extended rdata.

Test Plan:
- LB at 0x1003, memory word 0x80FF_1234, addr_ok and data_ok both in the REQ cycle:
  - data_wstrb=0000.
  - DONE on the next cycle: rdata_o=0xFFFF_FF80, done_o pulses, stall_o high for exactly 1 cycle.
- SH at 0x2002 with wdata=0xAAAA_BEEF, addr_ok delayed 3 cycles, data_ok 2 later:
  - Request held stable throughout; wstrb=1100, data_wdata=0xBEEF_BEEF.
  - stall_o high for 6 cycles, then done_o.
- LHU at 0x3000, word 0x8001_8765: rdata_o=0x0000_8765. LW same word: rdata_o=0x8001_8765.
- Flush in WAIT before data_ok: DRAIN until data_ok, done_o never asserts, then a back-to-back SW is accepted and completes with wstrb=1111.
- resetn low during WAIT: next cycle IDLE, data_req=0, stall_o=0; a stale data_ok after reset is ignored.
- With MEM_ADDR_EXC_EN: LW at 0x4001 gives adel_o pulse, data_req never rises. Without it: the same access reads word 0x4000.
